sprite_engine: RTL and testbench

- Parametrised sprite controller for the pixel-plot framebuffer interface (x, y, colour, plot) at 160x120 by default.
- Clears the screen after reset and draws a solid SPR_W x SPR_H sprite at a start position.
- Once per frame tick, reads direction requests, then erases and redraws the sprite at its new, clamped position.
- Replaces the single hard-coded 4x4 player loop with configurable size, speed, bounds, colours and frame rate, plus skip-if-stationary and pending-tick behaviour.

---
 rtl/sprite_engine.sv | 165 ++++++++++++++++
 tb/tb_sprite_engine.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sprite_engine.sv
// rtl/sprite_engine.sv - clear-then-draw sprite controller driving a pixel-plot framebuffer
module sprite_engine #(
   parameter int         SCREEN_W    = 160,
   parameter int         SCREEN_H    = 120,
   parameter int         X_W         = 8,
   parameter int         Y_W         = 7,
   parameter int         SPR_W       = 4,
   parameter int         SPR_H       = 4,
   parameter int         START_X     = 80,
   parameter int         START_Y     = 50,
   parameter int         SPEED       = 1,
   parameter logic [2:0] FG_COLOUR   = 3'b010,
   parameter logic [2:0] BG_COLOUR   = 3'b000,
   parameter int         FRAME_TICKS = 833333
) (
   input  logic           CLOCK_50,
   input  logic           reset,
   input  logic           mv_left,
   input  logic           mv_right,
   input  logic           mv_up,
   input  logic           mv_down,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic [2:0]     colour,
   output logic           plot,
   output logic [X_W-1:0] pos_x,
   output logic [Y_W-1:0] pos_y,
   output logic           busy,
   output logic           frame_tick
);
   localparam int DIV_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(FRAME_TICKS - 1);
   localparam logic [X_W-1:0]   SCR_X_LAST = X_W'(SCREEN_W - 1);
   localparam logic [Y_W-1:0]   SCR_Y_LAST = Y_W'(SCREEN_H - 1);
   localparam logic [X_W-1:0]   SPR_I_LAST = X_W'(SPR_W - 1);
   localparam logic [Y_W-1:0]   SPR_J_LAST = Y_W'(SPR_H - 1);
   localparam logic [X_W-1:0]   START_XV   = X_W'(START_X);
   localparam logic [Y_W-1:0]   START_YV   = Y_W'(START_Y);
   localparam logic [X_W:0]     MAX_X      = (X_W+1)'(SCREEN_W - SPR_W);
   localparam logic [Y_W:0]     MAX_Y      = (Y_W+1)'(SCREEN_H - SPR_H);
   localparam logic [X_W:0]     STEP_X     = (X_W+1)'(SPEED);
   localparam logic [Y_W:0]     STEP_Y     = (Y_W+1)'(SPEED);

   typedef enum logic [2:0] {S_CLEAR, S_DRAW, S_IDLE, S_MOVE, S_ERASE} state_t;

   state_t           state_q;
   logic [DIV_W-1:0] div_q;
   logic             pend_q;
   logic [X_W-1:0]   cnt_x_q;
   logic [Y_W-1:0]   cnt_y_q;
   logic [X_W-1:0]   nx_q;
   logic [Y_W-1:0]   ny_q;
   logic [X_W:0]     px, nx_d;
   logic [Y_W:0]     py, ny_d;

   // One guard bit on each axis so the step-and-clamp cannot wrap.
   always_comb begin
      px   = {1'b0, pos_x};
      py   = {1'b0, pos_y};
      nx_d = px;
      ny_d = py;
      if (mv_left && !mv_right)
         nx_d = (px < STEP_X) ? '0 : px - STEP_X;
      else if (mv_right && !mv_left)
         nx_d = (px + STEP_X > MAX_X) ? MAX_X : px + STEP_X;
      if (mv_up && !mv_down)
         ny_d = (py < STEP_Y) ? '0 : py - STEP_Y;
      else if (mv_down && !mv_up)
         ny_d = (py + STEP_Y > MAX_Y) ? MAX_Y : py + STEP_Y;
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q    <= S_CLEAR;
         div_q      <= '0;
         pend_q     <= 1'b0;
         cnt_x_q    <= '0;
         cnt_y_q    <= '0;
         nx_q       <= START_XV;
         ny_q       <= START_YV;
         x          <= '0;
         y          <= '0;
         colour     <= 3'b000;
         plot       <= 1'b0;
         pos_x      <= START_XV;
         pos_y      <= START_YV;
         busy       <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         if (div_q == DIV_LAST) begin
            div_q      <= '0;
            frame_tick <= 1'b1;
         end else begin
            div_q      <= div_q + 1'b1;
            frame_tick <= 1'b0;
         end
         // A tick that lands while busy is remembered once; extras are lost.
         if (frame_tick && state_q != S_IDLE)
            pend_q <= 1'b1;
         plot <= 1'b0;

         case (state_q)
            S_CLEAR: begin
               plot   <= 1'b1;
               x      <= cnt_x_q;
               y      <= cnt_y_q;
               colour <= BG_COLOUR;
               if (cnt_x_q == SCR_X_LAST) begin
                  cnt_x_q <= '0;
                  if (cnt_y_q == SCR_Y_LAST) begin
                     cnt_y_q <= '0;
                     state_q <= S_DRAW;
                  end else begin
                     cnt_y_q <= cnt_y_q + 1'b1;
                  end
               end else begin
                  cnt_x_q <= cnt_x_q + 1'b1;
               end
            end
            S_DRAW, S_ERASE: begin
               plot   <= 1'b1;
               x      <= pos_x + cnt_x_q;
               y      <= pos_y + cnt_y_q;
               colour <= (state_q == S_DRAW) ? FG_COLOUR : BG_COLOUR;
               if (cnt_x_q == SPR_I_LAST) begin
                  cnt_x_q <= '0;
                  if (cnt_y_q == SPR_J_LAST) begin
                     cnt_y_q <= '0;
                     if (state_q == S_DRAW) begin
                        state_q <= S_IDLE;
                        busy    <= 1'b0;
                     end else begin
                        pos_x   <= nx_q;
                        pos_y   <= ny_q;
                        state_q <= S_DRAW;
                     end
                  end else begin
                     cnt_y_q <= cnt_y_q + 1'b1;
                  end
               end else begin
                  cnt_x_q <= cnt_x_q + 1'b1;
               end
            end
            S_IDLE: begin
               if (frame_tick || pend_q) begin
                  pend_q  <= 1'b0;
                  state_q <= S_MOVE;
                  busy    <= 1'b1;
               end
            end
            S_MOVE: begin
               nx_q <= nx_d[X_W-1:0];
               ny_q <= ny_d[Y_W-1:0];
               if (nx_d == px && ny_d == py) begin
                  state_q <= S_IDLE;
                  busy    <= 1'b0;
               end else begin
                  state_q <= S_ERASE;
               end
            end
            default: state_q <= S_CLEAR;
         endcase
      end
   end
endmodule

// File: tb/tb_sprite_engine.sv
// tb/tb_sprite_engine.sv - directed self-checking bench for sprite_engine
module tb_sprite_engine;
   logic       clk = 1'b0;
   logic       rst, ml, mr, mu, md;
   logic [7:0] x, pos_x;
   logic [6:0] y, pos_y;
   logic [2:0] col;
   logic       plot, busy, ft;

   logic       rst3, mu3;
   logic [7:0] x3, pos_x3;
   logic [6:0] y3, pos_y3;
   logic [2:0] col3;
   logic       plot3, busy3, ft3;

   int n_checks = 0;
   int n_err    = 0;
   int cap_x[64];
   int cap_y[64];
   int cap_c[64];

   always #5 clk = ~clk;

   sprite_engine #(.FRAME_TICKS(100)) dut (
      .CLOCK_50(clk), .reset(rst), .mv_left(ml), .mv_right(mr), .mv_up(mu), .mv_down(md),
      .x(x), .y(y), .colour(col), .plot(plot), .pos_x(pos_x), .pos_y(pos_y),
      .busy(busy), .frame_tick(ft)
   );

   // Small screen so the clamp/pending scenario runs in a few hundred cycles.
   sprite_engine #(.SCREEN_W(16), .SCREEN_H(12), .START_X(4), .START_Y(2), .SPEED(3),
                   .FRAME_TICKS(100)) dut3 (
      .CLOCK_50(clk), .reset(rst3), .mv_left(1'b0), .mv_right(1'b0), .mv_up(mu3), .mv_down(1'b0),
      .x(x3), .y(y3), .colour(col3), .plot(plot3), .pos_x(pos_x3), .pos_y(pos_y3),
      .busy(busy3), .frame_tick(ft3)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Waits for the next move to start, then records plots until busy drops.
   task automatic capture(output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if (busy) begin ok = 1'b1; break; end
      end
      if (!ok) return;
      ok = 1'b0;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (plot && n < 64) begin
            cap_x[n] = int'(x); cap_y[n] = int'(y); cap_c[n] = int'(col);
            n++;
         end
         if (!busy) begin ok = 1'b1; break; end
      end
   endtask

   initial begin
      int  n, bad, nr, ftk, p0, p1, p2;
      int  rises[4];
      bit  ok, prev_b;
      rst = 1'b1; rst3 = 1'b1;
      ml = 1'b0; mr = 1'b0; mu = 1'b0; md = 1'b0; mu3 = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst_plot", plot, 0);
      check_eq("rst_x", x, 0);
      check_eq("rst_y", y, 0);
      check_eq("rst_colour", col, 0);
      check_eq("rst_pos_x", pos_x, 80);
      check_eq("rst_pos_y", pos_y, 50);
      check_eq("rst_busy", busy, 1);
      check_eq("rst_tick", ft, 0);

      rst3 = 1'b0;
      prev_b = 1'b1; nr = 0; ftk = 0; p0 = 0; p1 = 0; p2 = 0;
      for (int k = 1; k <= 350; k++) begin
         @(negedge clk);
         if (ft3 && ftk == 0) ftk = k;
         if (busy3 && !prev_b && nr < 4) begin rises[nr] = k; nr++; end
         if (plot3) begin
            if (nr == 0) p0++; else if (nr == 1) p1++; else p2++;
         end
         prev_b = busy3;
      end
      check_eq("s3_first_tick", ftk, 100);
      check_eq("s3_move_count", nr, 2);
      check_eq("s3_pending_move_at", rises[0], 209);
      check_eq("s3_live_move_at", rises[1], 301);
      check_eq("s3_clear_draw_plots", p0, 208);
      check_eq("s3_up_plots", p1, 32);
      check_eq("s3_stationary_plots", p2, 0);
      check_eq("s3_pos_y_clamped", pos_y3, 0);
      check_eq("s3_pos_x", pos_x3, 4);

      rst = 1'b0;
      bad = 0;
      for (int yy = 0; yy < 120; yy++)
         for (int xx = 0; xx < 160; xx++) begin
            @(negedge clk);
            if (!(plot === 1'b1 && col === 3'd0 && int'(x) == xx && int'(y) == yy)) bad++;
         end
      check_eq("clear_scan_bad", bad, 0);
      bad = 0;
      for (int j = 0; j < 4; j++)
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (!(plot === 1'b1 && col === 3'd2 && int'(x) == 80 + i && int'(y) == 50 + j)) bad++;
         end
      check_eq("draw_bad", bad, 0);
      check_eq("busy_idle", busy, 0);

      capture(n, ok);
      check_eq("pend_move_ok", ok, 1);
      check_eq("pend_stationary_plots", n, 0);

      mr = 1'b1;
      capture(n, ok);
      check_eq("right_ok", ok, 1);
      check_eq("right_plots", n, 32);
      bad = 0;
      for (int k = 0; k < 32; k++) begin
         if (k < 16) begin
            if (cap_x[k] != 80 + k % 4 || cap_y[k] != 50 + k / 4 || cap_c[k] != 0) bad++;
         end else begin
            if (cap_x[k] != 81 + (k - 16) % 4 || cap_y[k] != 50 + (k - 16) / 4 || cap_c[k] != 2) bad++;
         end
      end
      check_eq("right_pixels_bad", bad, 0);
      check_eq("right_pos_x", pos_x, 81);
      check_eq("right_pos_y", pos_y, 50);

      bad = 0;
      for (int m = 0; m < 75; m++) begin
         capture(n, ok);
         if (!ok || n != 32) bad++;
      end
      check_eq("sat_moves_bad", bad, 0);
      check_eq("sat_pos_x", pos_x, 156);
      capture(n, ok);
      check_eq("sat_ok", ok, 1);
      check_eq("sat_plots", n, 0);
      check_eq("sat_pos_x_hold", pos_x, 156);

      ml = 1'b1; md = 1'b1;
      capture(n, ok);
      check_eq("diag_plots", n, 32);
      check_eq("diag_pos_x", pos_x, 156);
      check_eq("diag_pos_y", pos_y, 51);
      check_eq("diag_first_x", cap_x[0], 156);
      check_eq("diag_first_y", cap_y[0], 50);
      check_eq("diag_first_c", cap_c[0], 0);
      check_eq("diag_last_x", cap_x[31], 159);
      check_eq("diag_last_y", cap_y[31], 54);
      check_eq("diag_last_c", cap_c[31], 2);

      mr = 1'b0; md = 1'b0;
      ok = 1'b0;
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if (busy) begin ok = 1'b1; break; end
      end
      check_eq("erase_start", ok, 1);
      repeat (4) @(negedge clk);
      check_eq("erase_plotting", plot, 1);
      check_eq("erase_pos_hold", pos_x, 156);
      rst = 1'b1;
      @(negedge clk);
      check_eq("abort_plot", plot, 0);
      check_eq("abort_pos_x", pos_x, 80);
      check_eq("abort_pos_y", pos_y, 50);
      check_eq("abort_busy", busy, 1);
      rst = 1'b0;
      @(negedge clk);
      check_eq("restart_plot", plot, 1);
      check_eq("restart_x0", x, 0);
      check_eq("restart_y0", y, 0);
      check_eq("restart_colour", col, 0);
      @(negedge clk);
      check_eq("restart_x1", x, 1);
      check_eq("restart_y1", y, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
